bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_pkg.sv | 19 +
 rtl/bist_cnt.sv | 27 ++
 rtl/bist_controller.sv | 148 ++++++++++++++
 tb/tb_bist_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST session controller.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int          DEF_SCAN_LEN     = 8;
    localparam int          DEF_NUM_PATTERNS = 1024;
    localparam int          DEF_MISR_W       = 16;
    localparam logic [15:0] DEF_GOLDEN_SIG   = 16'h0000;

endpackage

// File: rtl/bist_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module bist_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bist_controller.sv
// Test-per-scan BIST session sequencer with registered control outputs.
// Optional abort input is enabled by defining BIST_ABORT_EN.
module bist_controller
    import bist_pkg::*;
#(
    parameter int                SCAN_LEN     = DEF_SCAN_LEN,
    parameter int                NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int                MISR_W       = DEF_MISR_W,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = MISR_W'(DEF_GOLDEN_SIG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bist_start,
`ifdef BIST_ABORT_EN
    input  logic              bist_abort,
`endif
    input  logic [MISR_W-1:0] misr_sig,
    output logic              bist_mode,
    output logic              seed_load,
    output logic              scan_en,
    output logic              lfsr_en,
    output logic              misr_en,
    output logic              bist_end,
    output logic              pass_nfail
);

    localparam int SH_W  = $clog2(SCAN_LEN + 1);
    localparam int PAT_W = $clog2(NUM_PATTERNS + 1);

    state_t r_state;
    logic   w_sh_load, w_sh_dec, w_sh_zero;
    logic   w_pat_load, w_pat_dec, w_pat_zero;

    // Counters hold "remaining minus one", so the zero flag marks the last cycle of a phase.
    assign w_sh_load  = (r_state == S_INIT) || (r_state == S_CAPTURE);
    assign w_sh_dec   = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
    assign w_pat_load = (r_state == S_INIT);
    assign w_pat_dec  = (r_state == S_CAPTURE);

    bist_cnt #(.W(SH_W)) u_shift_cnt (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_sh_load),
        .i_load_val (SH_W'(SCAN_LEN - 1)),
        .i_dec      (w_sh_dec),
        .o_zero     (w_sh_zero)
    );

    bist_cnt #(.W(PAT_W)) u_pat_cnt (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_pat_load),
        .i_load_val (PAT_W'(NUM_PATTERNS - 1)),
        .i_dec      (w_pat_dec),
        .o_zero     (w_pat_zero)
    );

    // Outputs are computed for the state being entered, so they line up with r_state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            bist_mode  <= 1'b0;
            seed_load  <= 1'b0;
            scan_en    <= 1'b0;
            lfsr_en    <= 1'b0;
            misr_en    <= 1'b0;
            bist_end   <= 1'b0;
            pass_nfail <= 1'b0;
`ifdef BIST_ABORT_EN
        end else if (bist_abort && r_state != S_IDLE && r_state != S_DONE) begin
            r_state    <= S_DONE;
            bist_mode  <= 1'b0;
            seed_load  <= 1'b0;
            scan_en    <= 1'b0;
            lfsr_en    <= 1'b0;
            misr_en    <= 1'b0;
            bist_end   <= 1'b1;
            pass_nfail <= 1'b0;
`endif
        end else begin
            bist_mode <= 1'b0;
            seed_load <= 1'b0;
            scan_en   <= 1'b0;
            lfsr_en   <= 1'b0;
            misr_en   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bist_start) begin
                        r_state   <= S_INIT;
                        bist_mode <= 1'b1;
                        seed_load <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_state   <= S_SHIFT;
                    bist_mode <= 1'b1;
                    scan_en   <= 1'b1;
                    lfsr_en   <= 1'b1;
                    misr_en   <= 1'b1;
                end
                S_SHIFT: begin
                    bist_mode <= 1'b1;
                    if (w_sh_zero) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        scan_en <= 1'b1;
                        lfsr_en <= 1'b1;
                        misr_en <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    bist_mode <= 1'b1;
                    scan_en   <= 1'b1;
                    misr_en   <= 1'b1;
                    if (w_pat_zero) begin
                        r_state <= S_UNLOAD;
                    end else begin
                        r_state <= S_SHIFT;
                        lfsr_en <= 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (w_sh_zero) begin
                        r_state <= S_COMPARE;
                    end else begin
                        bist_mode <= 1'b1;
                        scan_en   <= 1'b1;
                        misr_en   <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    r_state    <= S_DONE;
                    bist_end   <= 1'b1;
                    pass_nfail <= (misr_sig == GOLDEN_SIG);
                end
                S_DONE: begin
                    if (!bist_start) begin
                        r_state    <= S_IDLE;
                        bist_end   <= 1'b0;
                        pass_nfail <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: random stimulus checked every cycle against a session-timeline model.
// Abort scenario is compiled in when BIST_ABORT_EN is defined.
module tb_bist_controller;

    localparam int          SL       = 8;
    localparam int          NP       = 4;
    localparam int          MW       = 16;
    localparam logic [15:0] GOLD     = 16'hA5C3;
    localparam int          TOTAL    = 1 + NP * (SL + 1) + SL + 1;
    localparam int          SCAN_CYC = NP * SL + SL;

    logic          clock = 1'b0;
    logic          reset;
    logic          bist_start;
    logic [MW-1:0] misr_sig;
    logic          abort_drv;
    logic          bist_mode, seed_load, scan_en, lfsr_en, misr_en, bist_end, pass_nfail;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_mode;
    int   m_t;
    logic m_pass;
    int   force_mode;
    int   since, rise_lat, scan_cnt;
    logic prev_end;

    always #5 clock = ~clock;

    bist_controller #(
        .SCAN_LEN     (SL),
        .NUM_PATTERNS (NP),
        .MISR_W       (MW),
        .GOLDEN_SIG   (GOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bist_start (bist_start),
`ifdef BIST_ABORT_EN
        .bist_abort (abort_drv),
`endif
        .misr_sig   (misr_sig),
        .bist_mode  (bist_mode),
        .seed_load  (seed_load),
        .scan_en    (scan_en),
        .lfsr_en    (lfsr_en),
        .misr_en    (misr_en),
        .bist_end   (bist_end),
        .pass_nfail (pass_nfail)
    );

    // Expected {bist_mode, seed_load, scan_en, lfsr_en, misr_en, bist_end, pass_nfail}
    // from the position m_t within the session timeline.
    function automatic logic [6:0] exp_out();
        if (m_mode == 0) return 7'b0000000;
        if (m_mode == 2) return {5'b00000, 1'b1, m_pass};
        if (m_t == 0) return 7'b1100000;
        if (m_t <= NP * (SL + 1)) return (((m_t - 1) % (SL + 1)) < SL) ? 7'b1011100 : 7'b1000000;
        if (m_t <= NP * (SL + 1) + SL) return 7'b1010100;
        return 7'b0000000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (force_mode != 0 && m_mode == 1 && m_t == TOTAL - 1)
            misr_sig = (force_mode == 1) ? GOLD : (GOLD ^ 16'h0001);
        else
            misr_sig = 16'($urandom);
        @(posedge clock);
        since++;
        if (!reset) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (bist_start) begin
                m_mode = 1; m_t = 0; since = 0; scan_cnt = 0; rise_lat = -1;
            end
        end else if (m_mode == 1) begin
            if (abort_drv) begin
                m_mode = 2; m_pass = 1'b0;
            end else begin
                m_t++;
                if (m_t == TOTAL) begin
                    m_mode = 2; m_pass = (misr_sig == GOLD);
                end
            end
        end else if (!bist_start) begin
            m_mode = 0;
        end
        #1;
        chk("outputs", {bist_mode, seed_load, scan_en, lfsr_en, misr_en, bist_end, pass_nfail}, exp_out());
        chk("seed_load_outside_init", seed_load & ~(m_mode == 1 && m_t == 0), 0);
        chk("lfsr_en_without_scan_en", lfsr_en & ~scan_en, 0);
        if (scan_en) scan_cnt++;
        if (bist_end && !prev_end && rise_lat < 0) rise_lat = since;
        prev_end = bist_end;
    endtask

    task automatic run_session(input int fm, input bit rand_start);
        force_mode = fm;
        bist_start = 1'b1;
        step();
        for (int i = 1; i <= TOTAL; i++) begin
            bist_start = rand_start ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        chk("bist_end_latency", rise_lat, TOTAL);
        chk("scan_en_cycles", scan_cnt, SCAN_CYC);
        chk("pass_nfail_session", pass_nfail, (fm == 1) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b0; bist_start = 1'b1; abort_drv = 1'b0; misr_sig = '0;
        m_mode = 0; m_t = 0; m_pass = 1'b0; force_mode = 0;
        since = 0; rise_lat = -1; scan_cnt = 0; prev_end = 1'b0;

        // reset sampled together with bist_start: reset wins
        repeat (3) step();
        chk("reset_state", {bist_mode, seed_load, scan_en, lfsr_en, misr_en, bist_end, pass_nfail}, 0);
        reset = 1'b1; bist_start = 1'b0;
        repeat (2) step();

        // matching signature, bist_start toggling mid-session
        run_session(1, 1'b1);
        bist_start = 1'b0;
        repeat (2) step();

        // mismatching signature, then bist_start held after DONE
        run_session(2, 1'b0);
        bist_start = 1'b1;
        repeat (4) step();
        chk("bist_end_held", bist_end, 1);
        bist_start = 1'b0;
        step();
        chk("bist_end_dropped", bist_end, 0);
        step();

        // reset in cycle 20, then a fresh session
        force_mode = 0;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        repeat (19) step();
        reset = 1'b0;
        step();
        chk("reset_mid_session", {bist_mode, seed_load, scan_en, lfsr_en, misr_en, bist_end, pass_nfail}, 0);
        reset = 1'b1;
        step();
        run_session(1, 1'b0);
        bist_start = 1'b0;
        repeat (2) step();

        // randomized sessions with occasional reset
        for (int s = 0; s < 6; s++) begin
            force_mode = $urandom_range(0, 2);
            bist_start = 1'b0;
            repeat ($urandom_range(0, 5)) step();
            bist_start = 1'b1;
            for (int i = 0; i < TOTAL + 10; i++) begin
                reset = ($urandom_range(0, 79) != 0);
                step();
                reset = 1'b1;
                bist_start = 1'($urandom_range(0, 1));
            end
        end
        bist_start = 1'b0;
        repeat (2) step();

`ifdef BIST_ABORT_EN
        force_mode = 0;
        bist_start = 1'b1;
        step();
        repeat (9) step();
        abort_drv = 1'b1;
        step();
        chk("abort_bist_end", bist_end, 1);
        chk("abort_pass_nfail", pass_nfail, 0);
        abort_drv = 1'b0;
        bist_start = 1'b0;
        step();
        chk("abort_return_idle", bist_end, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
